alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It executes the existing logical/arithmetic ops with one registered cycle of latency, and adds iterative signed/unsigned multiply and divide that produce HI/LO results. It sits in the execute stage behind a start/done handshake, so the pipeline control can stall while `busy` is high.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_muldiv_iter.sv | 117 +++++++++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - ALU control codes, sequencer state type and opcode classifiers
package alu_seq_pkg;

   // Codes 4'b1000..4'b1011 are reserved for the iterative multiply/divide ops.
   typedef enum logic [3:0] {
      CTL_AND   = 4'b0000,
      CTL_OR    = 4'b0001,
      CTL_ADD   = 4'b0010,
      CTL_SUB   = 4'b0110,
      CTL_SLT   = 4'b0111,
      CTL_MULT  = 4'b1000,
      CTL_MULTU = 4'b1001,
      CTL_DIV   = 4'b1010,
      CTL_DIVU  = 4'b1011,
      CTL_NOR   = 4'b1100,
      CTL_XOR   = 4'b1101
   } alu_ctl_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } alu_seq_state_t;

   function automatic logic is_mul(input logic [3:0] c);
      return (c == CTL_MULT) || (c == CTL_MULTU);
   endfunction

   function automatic logic is_div(input logic [3:0] c);
      return (c == CTL_DIV) || (c == CTL_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [3:0] c);
      return (c == CTL_MULT) || (c == CTL_DIV);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/done request and result bundle of the sequential ALU
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       ctl;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] hi;
   logic             zero;
   logic             oflow;
   logic             divz;

   modport master (
      output start, ctl, a, b,
      input  busy, done, out, hi, zero, oflow, divz
   );

   modport slave (
      input  start, ctl, a, b,
      output busy, done, out, hi, zero, oflow, divz
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - WIDTH-step shift-add multiplier / restoring divider datapath
// Divider half is built only when ALU_SEQ_DIV_EN is defined.
module alu_muldiv_iter
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [3:0]       ctl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic [WIDTH-1:0]   m_r;
   logic [CW-1:0]      cnt;
   logic               neg_lo;
   logic               sgn;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     m_sum;
   logic [WIDTH-1:0]   hi_n;
   logic [WIDTH-1:0]   lo_n;
   logic [2*WIDTH-1:0] prod;
`ifdef ALU_SEQ_DIV_EN
   logic               div_r;
   logic               neg_hi;
   logic [WIDTH:0]     r_sh;
   logic [WIDTH-1:0]   r_diff;
   logic               r_ge;
`endif

   always_comb begin
      sgn   = is_signed_op(ctl);
      a_mag = (sgn && a[WIDTH-1]) ? -a : a;
      b_mag = (sgn && b[WIDTH-1]) ? -b : b;
   end

   // hi_r:lo_r is the running product (multiplier shifts out of lo_r) or
   // the partial remainder:dividend pair (quotient bits shift into lo_r).
   always_comb begin
      m_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : '0);
      hi_n  = m_sum[WIDTH:1];
      lo_n  = {m_sum[0], lo_r[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      r_sh   = {hi_r, lo_r[WIDTH-1]};
      r_diff = r_sh[WIDTH-1:0] - m_r;
      r_ge   = (r_sh >= {1'b0, m_r});
      if (div_r) begin
         hi_n = r_ge ? r_diff : r_sh[WIDTH-1:0];
         lo_n = {lo_r[WIDTH-2:0], r_ge};
      end
`endif
   end

   // Sign fix-up is applied to the values the final step is about to produce.
   always_comb begin
      prod = {hi_n, lo_n};
      if (neg_lo) prod = -prod;
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_DIV_EN
      if (div_r) begin
         res_lo = neg_lo ? -lo_n : lo_n;
         res_hi = neg_hi ? -hi_n : hi_n;
      end
`endif
   end

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r   <= '0;
         lo_r   <= '0;
         m_r    <= '0;
         cnt    <= '0;
         neg_lo <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         div_r  <= 1'b0;
         neg_hi <= 1'b0;
`endif
      end else if (load) begin
         hi_r   <= '0;
         cnt    <= '0;
         neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_SEQ_DIV_EN
         div_r  <= is_div(ctl);
         neg_hi <= sgn && a[WIDTH-1];
         if (is_div(ctl)) begin
            m_r  <= b_mag;
            lo_r <= a_mag;
         end else begin
            m_r  <= a_mag;
            lo_r <= b_mag;
         end
`else
         m_r    <= a_mag;
         lo_r   <= b_mag;
`endif
      end else if (step) begin
         hi_r <= hi_n;
         lo_r <= lo_n;
         cnt  <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle ops plus iterative mul/div behind start/done
// Iterative DIV/DIVU are built only when ALU_SEQ_DIV_EN is defined.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);

   alu_seq_state_t   state;
   alu_seq_state_t   state_nx;
   logic             accept;
   logic             long_op;
   logic             div_zero;
   logic             iter_last;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] hi_q;
   logic             zero_q;
   logic             oflow_q;
   logic             busy_c;
   logic             done_c;

   assign accept = (state == ST_IDLE) && bus.start;

`ifdef ALU_SEQ_DIV_EN
   assign div_zero = is_div(bus.ctl) && (bus.b == '0);
   assign long_op  = is_mul(bus.ctl) || (is_div(bus.ctl) && !div_zero);
`else
   assign div_zero = 1'b0;
   assign long_op  = is_mul(bus.ctl);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (bus.start) state_nx = long_op ? ST_ITER : ST_DONE;
         ST_ITER: if (iter_last) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_c = (state != ST_IDLE);
      done_c = (state == ST_DONE);
   end

   // SLT takes the sign of a-b corrected by the subtract overflow.
   always_comb begin
      sum     = bus.a + bus.b;
      diff    = bus.a - bus.b;
      add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      alu_res = '0;
      alu_ovf = 1'b0;
      case (bus.ctl)
         CTL_AND: alu_res = bus.a & bus.b;
         CTL_OR:  alu_res = bus.a | bus.b;
         CTL_ADD: begin
            alu_res = sum;
            alu_ovf = add_ovf;
         end
         CTL_SUB: begin
            alu_res = diff;
            alu_ovf = sub_ovf;
         end
         CTL_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
         CTL_NOR: alu_res = ~(bus.a | bus.b);
         CTL_XOR: alu_res = bus.a ^ bus.b;
         default: alu_res = '0;
      endcase
   end

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .load   (accept && long_op),
      .step   (state == ST_ITER),
      .ctl    (bus.ctl),
      .a      (bus.a),
      .b      (bus.b),
      .last   (iter_last),
      .res_lo (res_lo),
      .res_hi (res_hi)
   );

   // Long ops leave out/hi untouched until the final iteration writes them.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         hi_q    <= '0;
         zero_q  <= 1'b1;
         oflow_q <= 1'b0;
      end else if (accept) begin
         oflow_q <= 1'b0;
         if (div_zero) begin
            out_q  <= '1;
            hi_q   <= bus.a;
            zero_q <= 1'b0;
         end else if (!long_op) begin
            out_q   <= alu_res;
            zero_q  <= (alu_res == '0);
            oflow_q <= alu_ovf;
         end
      end else if ((state == ST_ITER) && iter_last) begin
         out_q  <= res_lo;
         hi_q   <= res_hi;
         zero_q <= (res_lo == '0);
      end
   end

`ifdef ALU_SEQ_DIV_EN
   logic divz_q;

   always_ff @(posedge clk) begin
      if (rst)                            divz_q <= 1'b0;
      else if (accept && is_div(bus.ctl)) divz_q <= div_zero;
   end

   assign bus.divz = divz_q;
`else
   assign bus.divz = 1'b0;
`endif

   assign bus.busy  = busy_c;
   assign bus.done  = done_c;
   assign bus.out   = out_q;
   assign bus.hi    = hi_q;
   assign bus.zero  = zero_q;
   assign bus.oflow = oflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed self-checking bench for alu_seq (WIDTH=32)
module tb_alu_seq;
   import alu_seq_pkg::*;

   typedef struct packed {
      logic [7:0]  lat;
      logic        busy_ok;
      logic [31:0] out;
      logic [31:0] hi;
      logic        zero;
      logic        oflow;
      logic        divz;
   } res_t;

   localparam res_t RST_VAL = '{lat: 8'd0, busy_ok: 1'b1, out: 32'd0, hi: 32'd0,
                                zero: 1'b1, oflow: 1'b0, divz: 1'b0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   res_t m_prev;

   logic [31:0] bnd [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
   logic [3:0]  ops [11] = '{CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR, CTL_XOR,
                             CTL_MULT, CTL_MULTU, CTL_DIV, CTL_DIVU};

   alu_seq_if #(.WIDTH(32)) bus ();

   alu_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic string fmt(input res_t r);
      return $sformatf("lat=%0d busy_ok=%0b out=%h hi=%h zero=%0b oflow=%0b divz=%0b",
                       r.lat, r.busy_ok, r.out, r.hi, r.zero, r.oflow, r.divz);
   endfunction

   // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
   function automatic res_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input res_t prev);
      res_t e;
      longint sa, sb, r;
      longint unsigned ua, ub, ur;
      e = prev;
      e.lat = 8'd1;
      e.busy_ok = 1'b1;
      e.oflow = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (c)
         CTL_AND: e.out = a & b;
         CTL_OR:  e.out = a | b;
         CTL_NOR: e.out = ~(a | b);
         CTL_XOR: e.out = a ^ b;
         CTL_ADD: begin
            r = sa + sb;
            e.out = r[31:0];
            e.oflow = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         CTL_SUB: begin
            r = sa - sb;
            e.out = r[31:0];
            e.oflow = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         CTL_SLT: e.out = (sa < sb) ? 32'd1 : 32'd0;
         CTL_MULT: begin
            r = sa * sb;
            e.out = r[31:0];
            e.hi = r[63:32];
            e.lat = 8'd33;
         end
         CTL_MULTU: begin
            ur = ua * ub;
            e.out = ur[31:0];
            e.hi = ur[63:32];
            e.lat = 8'd33;
         end
`ifdef ALU_SEQ_DIV_EN
         CTL_DIV, CTL_DIVU: begin
            if (b == 32'd0) begin
               e.out = 32'hFFFF_FFFF;
               e.hi = a;
               e.divz = 1'b1;
            end else begin
               e.divz = 1'b0;
               e.lat = 8'd33;
               if (c == CTL_DIV) begin
                  r = sa / sb;
                  e.out = r[31:0];
                  r = sa % sb;
                  e.hi = r[31:0];
               end else begin
                  ur = ua / ub;
                  e.out = ur[31:0];
                  ur = ua % ub;
                  e.hi = ur[31:0];
               end
            end
         end
`endif
         default: e.out = 32'd0;
      endcase
      e.zero = (e.out == 32'd0);
      return e;
   endfunction

   function automatic logic [31:0] rnd_opnd();
      int v;
      case ($urandom_range(0, 3))
         0: return bnd[$urandom_range(0, 4)];
         1: begin
            v = int'($urandom_range(0, 16)) - 8;
            return 32'(v);
         end
         default: return $urandom();
      endcase
   endfunction

   // Called #1 after a rising edge with the DUT idle; returns #1 after the cycle following done.
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output res_t o);
      int   cyc;
      logic bok;
      bus.start = 1'b1;
      bus.ctl = c;
      bus.a = a;
      bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 1;
      bok = 1'b1;
      while (!bus.done && cyc < 80) begin
         if (!bus.busy) bok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      if (!bus.busy) bok = 1'b0;
      o = '{lat: 8'(cyc), busy_ok: bok, out: bus.out, hi: bus.hi, zero: bus.zero,
            oflow: bus.oflow, divz: bus.divz};
      @(posedge clk); #1;
      if (bus.busy || bus.done) o.busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      res_t o;
      rst = 1'b1;
      bus.start = 1'b1;
      bus.ctl = CTL_ADD;
      bus.a = 32'd5;
      bus.b = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_busy_done got %b expected 00", {bus.busy, bus.done});
      end
      o = '{lat: 8'd0, busy_ok: 1'b1, out: bus.out, hi: bus.hi, zero: bus.zero,
            oflow: bus.oflow, divz: bus.divz};
      n_tests++;
      if (o !== RST_VAL) begin
         n_fail++;
         $display("FAIL reset_outputs got %s expected %s", fmt(o), fmt(RST_VAL));
      end
      rst = 1'b0;
      bus.start = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_priority busy got %b expected 0", bus.busy);
      end
      m_prev = RST_VAL;
   endtask

   task automatic test_directed();
      logic [3:0]  dc [16] = '{CTL_ADD, CTL_MULT, CTL_MULTU, CTL_DIV, CTL_DIVU, CTL_DIV, CTL_SUB, CTL_SLT,
                               CTL_SLT, CTL_XOR, CTL_NOR, 4'b0100, CTL_DIV, CTL_DIVU, CTL_MULT, CTL_AND};
      logic [31:0] da [16] = '{32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h1234_5678,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hA5A5_0F0F,
                               32'h0F0F_00FF, 32'h1111_2222, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'hF0F0_F0F0};
      logic [31:0] db [16] = '{32'h0000_0001, 32'h0000_0005, 32'h0000_0002, 32'h0000_0002, 32'h0000_0000,
                               32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_0000,
                               32'h00F0_0F00, 32'h3333_4444, 32'h0000_0000, 32'h0000_0003, 32'h8000_0000,
                               32'h0F0F_0F0F};
      res_t e, o;
      for (int i = 0; i < 16; i++) begin
         e = model(dc[i], da[i], db[i], m_prev);
         run_op(dc[i], da[i], db[i], o);
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL directed[%0d] ctl=%h a=%h b=%h got %s expected %s", i, dc[i], da[i], db[i], fmt(o), fmt(e));
         end
         m_prev = e;
      end
   endtask

   task automatic test_random();
      res_t e, o;
      logic [3:0]  c;
      logic [31:0] a, b;
      int idx;
      for (int i = 0; i < 60; i++) begin
         idx = $urandom_range(0, 11);
         c = (idx == 11) ? 4'($urandom_range(0, 15)) : ops[idx];
         a = rnd_opnd();
         b = rnd_opnd();
         e = model(c, a, b, m_prev);
         run_op(c, a, b, o);
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random[%0d] ctl=%h a=%h b=%h got %s expected %s", i, c, a, b, fmt(o), fmt(e));
         end
         m_prev = e;
      end
   endtask

   task automatic test_ignore_start();
      res_t e, o;
      int   cyc;
      logic bok;
      e = model(CTL_MULT, 32'hFFFF_FF85, 32'h0001_0003, m_prev);
      bus.start = 1'b1;
      bus.ctl = CTL_MULT;
      bus.a = 32'hFFFF_FF85;
      bus.b = 32'h0001_0003;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 1;
      bok = 1'b1;
      while (!bus.done && cyc < 80) begin
         if (!bus.busy) bok = 1'b0;
         bus.start = (cyc == 5);
         if (cyc == 5) begin
            bus.ctl = CTL_ADD;
            bus.a = 32'd1;
            bus.b = 32'd2;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!bus.busy) bok = 1'b0;
      o = '{lat: 8'(cyc), busy_ok: bok, out: bus.out, hi: bus.hi, zero: bus.zero,
            oflow: bus.oflow, divz: bus.divz};
      bus.start = 1'b1;
      bus.ctl = CTL_XOR;
      bus.a = 32'h1234_5678;
      bus.b = 32'h0000_FFFF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.busy || bus.done) o.busy_ok = 1'b0;
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL ignore_start got %s expected %s", fmt(o), fmt(e));
      end
      m_prev = e;
   endtask

   task automatic test_abort();
      res_t e, o;
      int   seen_done;
      bus.start = 1'b1;
      bus.ctl = CTL_MULT;
      bus.a = 32'h0000_1234;
      bus.b = 32'hFFFF_0001;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int cyc = 1; cyc < 10; cyc++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      bus.start = 1'b1;
      bus.ctl = CTL_ADD;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.start = 1'b0;
      o = '{lat: 8'd0, busy_ok: !bus.busy, out: bus.out, hi: bus.hi, zero: bus.zero,
            oflow: bus.oflow, divz: bus.divz};
      n_tests++;
      if (o !== RST_VAL) begin
         n_fail++;
         $display("FAIL abort_outputs got %s expected %s", fmt(o), fmt(RST_VAL));
      end
      seen_done = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (bus.done || bus.busy) seen_done++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (seen_done !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done busy/done cycles got %0d expected 0", seen_done);
      end
      m_prev = RST_VAL;
      e = model(CTL_SUB, 32'd3, 32'd10, m_prev);
      run_op(CTL_SUB, 32'd3, 32'd10, o);
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL abort_recover got %s expected %s", fmt(o), fmt(e));
      end
      m_prev = e;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
